// File: rtl/instr_decoder_pipe_if.sv
// Fetch-to-decode handshake bundle: instruction words in, decoded fields out.
// The master modport is the fetch/consumer side; the decode stage uses slave.
interface instr_decoder_pipe_if #(
  parameter int OP_W  = 4,
  parameter int REG_W = 2
) ();
  localparam int IW = OP_W + 2 * REG_W;

  logic             in_valid;
  logic             in_ready;
  logic [IW-1:0]    in_word;
  logic             out_valid;
  logic             out_ready;
  logic [OP_W-1:0]  out_op_code;
  logic [REG_W-1:0] out_dst;
  logic [REG_W-1:0] out_src;
  logic [IW-1:0]    out_imm;
  logic             out_has_imm;
  logic             out_illegal;

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_op_code, out_dst, out_src,
           out_imm, out_has_imm, out_illegal
  );

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_op_code, out_dst, out_src,
           out_imm, out_has_imm, out_illegal
  );
endinterface

// File: rtl/instr_decoder_pipe.sv
// Decode stage: splits {op,dst,src}, merges a trailing immediate for two-word ops; 1-cycle latency, output held while !out_ready.
// Optional handshake statistics counters (saturating) built when DECODE_STATS_EN is defined.
module instr_decoder_pipe #(
  parameter int                    OP_W         = 4,
  parameter int                    REG_W        = 2,
  parameter logic [2**OP_W-1:0]    IMM_OP_MASK  = 16'hF000,
  parameter logic [2**OP_W-1:0]    ILLEGAL_MASK = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_decoder_pipe_if.slave  bus
`ifdef DECODE_STATS_EN
  ,
  output logic [15:0]          stat_instr_count,
  output logic [15:0]          stat_illegal_count
`endif
);
  localparam int IW = OP_W + 2 * REG_W;

  typedef enum logic {S_OP, S_IMM} state_t;

  state_t           state_q, state_d;
  logic [OP_W-1:0]  pend_op_q, pend_op_d;
  logic [REG_W-1:0] pend_dst_q, pend_dst_d;
  logic [REG_W-1:0] pend_src_q, pend_src_d;

  logic             out_valid_q, out_valid_d;
  logic [OP_W-1:0]  out_op_q, out_op_d;
  logic [REG_W-1:0] out_dst_q, out_dst_d;
  logic [REG_W-1:0] out_src_q, out_src_d;
  logic [IW-1:0]    out_imm_q, out_imm_d;
  logic             out_has_imm_q, out_has_imm_d;
  logic             out_illegal_q, out_illegal_d;

  logic             in_ready;
  logic             accept;
  logic [OP_W-1:0]  word_op;
  logic [REG_W-1:0] word_dst;
  logic [REG_W-1:0] word_src;
  logic             word_illegal;
  logic             word_two;

  assign in_ready     = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && in_ready;
  assign word_op      = bus.in_word[IW-1 -: OP_W];
  assign word_dst     = bus.in_word[2*REG_W-1 -: REG_W];
  assign word_src     = bus.in_word[REG_W-1:0];
  assign word_illegal = ILLEGAL_MASK[word_op];
  // An illegal opcode never waits for an immediate, even if flagged two-word.
  assign word_two     = IMM_OP_MASK[word_op] && !word_illegal;

  always_comb begin
    state_d       = state_q;
    pend_op_d     = pend_op_q;
    pend_dst_d    = pend_dst_q;
    pend_src_d    = pend_src_q;
    out_valid_d   = out_valid_q;
    out_op_d      = out_op_q;
    out_dst_d     = out_dst_q;
    out_src_d     = out_src_q;
    out_imm_d     = out_imm_q;
    out_has_imm_d = out_has_imm_q;
    out_illegal_d = out_illegal_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      case (state_q)
        S_OP: begin
          if (word_two) begin
            pend_op_d  = word_op;
            pend_dst_d = word_dst;
            pend_src_d = word_src;
            state_d    = S_IMM;
          end else begin
            out_valid_d   = 1'b1;
            out_op_d      = word_op;
            out_dst_d     = word_dst;
            out_src_d     = word_src;
            out_imm_d     = '0;
            out_has_imm_d = 1'b0;
            out_illegal_d = word_illegal;
          end
        end
        S_IMM: begin
          out_valid_d   = 1'b1;
          out_op_d      = pend_op_q;
          out_dst_d     = pend_dst_q;
          out_src_d     = pend_src_q;
          out_imm_d     = bus.in_word;
          out_has_imm_d = 1'b1;
          out_illegal_d = 1'b0;
          state_d       = S_OP;
        end
        default: state_d = S_OP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_OP;
      pend_op_q     <= '0;
      pend_dst_q    <= '0;
      pend_src_q    <= '0;
      out_valid_q   <= 1'b0;
      out_op_q      <= '0;
      out_dst_q     <= '0;
      out_src_q     <= '0;
      out_imm_q     <= '0;
      out_has_imm_q <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_op_q     <= pend_op_d;
      pend_dst_q    <= pend_dst_d;
      pend_src_q    <= pend_src_d;
      out_valid_q   <= out_valid_d;
      out_op_q      <= out_op_d;
      out_dst_q     <= out_dst_d;
      out_src_q     <= out_src_d;
      out_imm_q     <= out_imm_d;
      out_has_imm_q <= out_has_imm_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_op_code = out_op_q;
  assign bus.out_dst     = out_dst_q;
  assign bus.out_src     = out_src_q;
  assign bus.out_imm     = out_imm_q;
  assign bus.out_has_imm = out_has_imm_q;
  assign bus.out_illegal = out_illegal_q;

`ifdef DECODE_STATS_EN
  logic [15:0] stat_instr_q, stat_instr_d;
  logic [15:0] stat_illegal_q, stat_illegal_d;

  // Counts output handshakes; both counters stick at all-ones.
  always_comb begin
    stat_instr_d   = stat_instr_q;
    stat_illegal_d = stat_illegal_q;
    if (out_valid_q && bus.out_ready) begin
      if (stat_instr_q != 16'hFFFF) stat_instr_d = stat_instr_q + 16'd1;
      if (out_illegal_q && stat_illegal_q != 16'hFFFF) stat_illegal_d = stat_illegal_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_instr_q   <= '0;
      stat_illegal_q <= '0;
    end else begin
      stat_instr_q   <= stat_instr_d;
      stat_illegal_q <= stat_illegal_d;
    end
  end

  assign stat_instr_count   = stat_instr_q;
  assign stat_illegal_count = stat_illegal_q;
`endif
endmodule
